// File: rtl/direction_filter.sv
// direction_filter: debounced tilt-to-heading filter with dead-zone, axis hysteresis and no-reverse rule
module direction_filter #(
  parameter int WIDTH = 10,
  parameter int DEADZONE = 50,
  parameter int HYST = 8,
  parameter int STABLE_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] input_x,
  input  logic [WIDTH-1:0] input_y,
  output logic [2:0]       direction,
  output logic             flat,
  output logic             dir_changed,
  output logic             reverse_reject
);
  localparam int CW = $clog2(STABLE_COUNT + 1) < 1 ? 1 : $clog2(STABLE_COUNT + 1);
  localparam logic [2:0] NONE = 3'b100;
  localparam logic [WIDTH-1:0] DZ = WIDTH'(DEADZONE);
  localparam logic [WIDTH-1:0] HY = WIDTH'(HYST);
  localparam logic [CW-1:0] SC = CW'(STABLE_COUNT);
  logic [WIDTH-1:0] ax, ay, other, held;
  logic [2:0] pending, cand;
  logic [CW-1:0] cnt, cnt_nxt;
  logic naive_y, sel_y, same, hit, rev;
  // One's-complement magnitudes, widened by a bit so the hysteresis sum cannot wrap
  assign ax = {1'b0, input_x[WIDTH-1] ? ~input_x[WIDTH-2:0] : input_x[WIDTH-2:0]};
  assign ay = {1'b0, input_y[WIDTH-1] ? ~input_y[WIDTH-2:0] : input_y[WIDTH-2:0]};
  // Candidate heading, debounce bookkeeping and reversal detection
  always_comb begin
    naive_y = ay > ax;
    other = naive_y ? ay : ax;
    held = direction[0] ? ay : ax;
    sel_y = (!direction[2] && naive_y != direction[0] && !(other > held + HY)) ? direction[0] : naive_y;
    cand = (ax < DZ && ay < DZ) ? NONE : {1'b0, sel_y ? input_y[WIDTH-1] : ~input_x[WIDTH-1], sel_y};
    same = cand == pending;
    cnt_nxt = same ? (cnt == SC ? cnt : cnt + CW'(1)) : CW'(1);
    hit = cnt_nxt == SC && (!same || cnt != SC);
    rev = !direction[2] && !cand[2] && cand[0] == direction[0] && cand[1] != direction[1];
  end
  // Registered heading state; reset and clear both return to the no-direction state
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      direction <= NONE;
      pending <= NONE;
      cnt <= '0;
      flat <= 1'b1;
      dir_changed <= 1'b0;
      reverse_reject <= 1'b0;
    end else begin
      dir_changed <= 1'b0;
      reverse_reject <= 1'b0;
      if (sample_valid) begin
        pending <= cand;
        cnt <= cnt_nxt;
        flat <= cand[2];
        if (hit && !cand[2] && cand != direction) begin
          if (rev) begin
            reverse_reject <= 1'b1;
          end else begin
            direction <= cand;
            dir_changed <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_direction_filter.sv
// tb_direction_filter: directed and randomized checks of direction_filter against a behavioural model
module tb_direction_filter;
  localparam int S = 4;
  logic clk = 0, reset = 1, clear = 0, sample_valid = 0;
  logic [9:0] input_x = 0, input_y = 0;
  logic [2:0] direction;
  logic flat, dir_changed, reverse_reject;
  int n_cmp = 0, n_bad = 0;
  logic [2:0] m_dir = 3'b100, m_pend = 3'b100;
  logic m_flat = 1, m_chg = 0, m_rej = 0;
  int m_run = 0;

  direction_filter #(.WIDTH(10), .DEADZONE(50), .HYST(8), .STABLE_COUNT(S)) dut (
    .clk(clk), .reset(reset), .clear(clear), .sample_valid(sample_valid),
    .input_x(input_x), .input_y(input_y), .direction(direction), .flat(flat),
    .dir_changed(dir_changed), .reverse_reject(reverse_reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] mcand(input int x, input int y);
    int ax, ay;
    bit use_y;
    ax = x < 0 ? -x - 1 : x;
    ay = y < 0 ? -y - 1 : y;
    if (ax < 50 && ay < 50) return 3'b100;
    use_y = ay > ax;
    if (!m_dir[2] && use_y != m_dir[0]) begin
      if (!((use_y ? ay : ax) > (m_dir[0] ? ay : ax) + 8)) use_y = m_dir[0];
    end
    return use_y ? {1'b0, y < 0, 1'b1} : {1'b0, x >= 0, 1'b0};
  endfunction

  task automatic step(input bit v, input int x, input int y, input bit c);
    logic [2:0] cd;
    @(negedge clk);
    sample_valid = v;
    clear = c;
    input_x = x[9:0];
    input_y = y[9:0];
    m_chg = 0;
    m_rej = 0;
    if (c) begin
      m_dir = 3'b100; m_pend = 3'b100; m_run = 0; m_flat = 1;
    end else if (v) begin
      cd = mcand(x, y);
      if (cd == m_pend) m_run++;
      else begin m_pend = cd; m_run = 1; end
      m_flat = cd[2];
      if (m_run == S && !cd[2] && cd != m_dir) begin
        if (!m_dir[2] && cd[0] == m_dir[0]) m_rej = 1;
        else begin m_dir = cd; m_chg = 1; end
      end
    end
    @(posedge clk);
    #1;
    chk("direction", direction, m_dir);
    chk("flat", {2'b0, flat}, {2'b0, m_flat});
    chk("dir_changed", {2'b0, dir_changed}, {2'b0, m_chg});
    chk("reverse_reject", {2'b0, reverse_reject}, {2'b0, m_rej});
    sample_valid = 0;
    clear = 0;
  endtask

  task automatic run(input int k, input int x, input int y);
    for (int i = 0; i < k; i++) step(1, x, y, 0);
  endtask

  initial begin
    int vals[10] = '{-300, -120, -60, -30, 0, 30, 60, 105, 120, 300};
    int x, y;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_direction", direction, 3'b100);
    chk("rst_flat", {2'b0, flat}, 3'b001);
    chk("rst_pulses", {1'b0, dir_changed, reverse_reject}, 3'b000);
    reset = 0;
    run(3, 200, 10);
    chk("three_samples_hold", direction, 3'b100);
    run(1, 200, 10);
    chk("commit_right", direction, 3'b010);
    run(4, -200, 0);
    chk("reverse_held", direction, 3'b010);
    run(4, -200, 0);
    run(4, 100, -105);
    chk("hyst_no_switch", direction, 3'b010);
    run(4, 100, -120);
    chk("hyst_switch_down", direction, 3'b011);
    run(6, -30, 40);
    chk("flat_holds", direction, 3'b011);
    chk("flat_set", {2'b0, flat}, 3'b001);
    run(4, 300, 0);
    run(4, 0, 300);
    chk("commit_up", direction, 3'b001);
    for (int i = 0; i < 8; i++) step(1, i[0] ? 200 : 0, i[0] ? 0 : 200, 0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) step(0, 0, 0, 0);
      step(1, -200, 0, 0);
    end
    chk("gap_commit_left", direction, 3'b000);
    run(2, 0, -200);
    step(0, 0, 0, 1);
    chk("clear_direction", direction, 3'b100);
    run(3, 0, -200);
    chk("clear_restart_hold", direction, 3'b100);
    run(1, 0, -200);
    chk("clear_restart_commit", direction, 3'b011);
    for (int i = 0; i < 300; i++) begin
      x = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 1023)) - 512 : vals[$urandom_range(0, 9)];
      y = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 1023)) - 512 : vals[$urandom_range(0, 9)];
      repeat ($urandom_range(1, 6)) begin
        repeat ($urandom_range(0, 2)) step(0, x, y, 0);
        step(1, x, y, $urandom_range(0, 39) == 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
